// File: rtl/flash_arbiter_if.sv
// Bus bundle between the two flash requesters, the arbiter and the SPI flash word-read engine.
// The arbiter connects through the slave modport; requesters and engine models use master.

interface flash_arbiter_if #(
    parameter int ADDR_W = 24
);
    // Handshake: a requester raises reqN_valid with reqN_addr stable and holds both until
    // reqN_ready pulses for one cycle; reqN_rdata/reqN_err are meaningful only in that cycle.
    // Toward the engine, mem_valid stays high with mem_addr stable until the engine pulses
    // mem_ready for one cycle with mem_rdata valid.
    logic              req0_valid;
    logic [ADDR_W-1:0] req0_addr;
    logic              req0_ready;
    logic [31:0]       req0_rdata;
    logic              req0_err;

    logic              req1_valid;
    logic [ADDR_W-1:0] req1_addr;
    logic              req1_ready;
    logic [31:0]       req1_rdata;
    logic              req1_err;

    logic              mem_valid;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ready;
    logic [31:0]       mem_rdata;

    modport slave (
        input  req0_valid, req0_addr, req1_valid, req1_addr, mem_ready, mem_rdata,
        output req0_ready, req0_rdata, req0_err, req1_ready, req1_rdata, req1_err,
               mem_valid, mem_addr
    );

    modport master (
        output req0_valid, req0_addr, req1_valid, req1_addr, mem_ready, mem_rdata,
        input  req0_ready, req0_rdata, req0_err, req1_ready, req1_rdata, req1_err,
               mem_valid, mem_addr
    );
endinterface

// File: rtl/flash_arbiter.sv
// Two-port round-robin arbiter in front of the SPI flash word-read engine (IDLE->ISSUE->DONE).
// Define ARB_TIMEOUT_EN to abort reads the engine never completes with an error response.

module flash_arbiter #(
    parameter int ADDR_W = 24
`ifdef ARB_TIMEOUT_EN
    ,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd4095
`endif
) (
    input  logic            clock,
    input  logic            resetn,
    flash_arbiter_if.slave  bus,
    output logic            busy,
    output logic [1:0]      dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              grant_q, grant_d;
    logic              last_grant_q;
    logic [ADDR_W-1:0] mem_addr_q, addr_d;
    logic [31:0]       rdata0_q, rdata1_q;
    logic              complete;
    logic              unused_addr_bits;

`ifdef ARB_TIMEOUT_EN
    logic [15:0]       timer_q;
    logic              err_q;
    logic              timed_out;
`endif

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        addr_d   = mem_addr_q;
        complete = 1'b0;
`ifdef ARB_TIMEOUT_EN
        timed_out = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (bus.req0_valid || bus.req1_valid) begin
                    // Contention goes to the port that did not win last time.
                    grant_d = (bus.req0_valid && bus.req1_valid) ? ~last_grant_q : bus.req1_valid;
                    addr_d  = grant_d ? {bus.req1_addr[ADDR_W-1:2], 2'b00}
                                      : {bus.req0_addr[ADDR_W-1:2], 2'b00};
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.mem_ready) begin
                    complete = 1'b1;
                    state_d  = DONE;
                end
`ifdef ARB_TIMEOUT_EN
                // timer_q counts finished ISSUE cycles; expiry lands on the TIMEOUT_CYCLES-th one.
                else if (timer_q + 16'd1 == TIMEOUT_CYCLES) begin
                    timed_out = 1'b1;
                    state_d   = DONE;
                end
`endif
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            mem_addr_q   <= '0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && state_d == ISSUE) begin
                grant_q      <= grant_d;
                last_grant_q <= grant_d;
                mem_addr_q   <= addr_d;
            end
            if (complete) begin
                if (grant_q) rdata1_q <= bus.mem_rdata;
                else         rdata0_q <= bus.mem_rdata;
            end
`ifdef ARB_TIMEOUT_EN
            if (timed_out) begin
                if (grant_q) rdata1_q <= 32'hFFFF_FFFF;
                else         rdata0_q <= 32'hFFFF_FFFF;
            end
`endif
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            timer_q <= '0;
            err_q   <= 1'b0;
        end else begin
            timer_q <= (state_q == ISSUE) ? timer_q + 16'd1 : 16'd0;
            if (complete)       err_q <= 1'b0;
            else if (timed_out) err_q <= 1'b1;
        end
    end
`endif

    assign bus.mem_valid  = (state_q == ISSUE);
    assign bus.mem_addr   = mem_addr_q;
    assign bus.req0_ready = (state_q == DONE) && !grant_q;
    assign bus.req1_ready = (state_q == DONE) &&  grant_q;
    assign bus.req0_rdata = rdata0_q;
    assign bus.req1_rdata = rdata1_q;
`ifdef ARB_TIMEOUT_EN
    assign bus.req0_err   = bus.req0_ready && err_q;
    assign bus.req1_err   = bus.req1_ready && err_q;
`else
    assign bus.req0_err   = 1'b0;
    assign bus.req1_err   = 1'b0;
`endif

    assign busy      = (state_q != IDLE);
    assign dbg_state = state_q;

    // Byte-lane bits are forced to zero on the flash side.
    assign unused_addr_bits = ^{bus.req0_addr[1:0], bus.req1_addr[1:0]};

endmodule

// File: tb/tb_flash_arbiter.sv
// Directed bench for flash_arbiter: table of single reads, then arbitration, reset and timeout
// sequences; flash engine is modelled by hand-driven mem_ready/mem_rdata.

module tb_flash_arbiter;

    logic        clock = 1'b0;
    logic        resetn;
    logic        busy;
    logic [1:0]  dbg_state;

    flash_arbiter_if #(.ADDR_W(24)) bus ();

    flash_arbiter #(
        .ADDR_W(24)
`ifdef ARB_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES(16'd16)
`endif
    ) dut (
        .clock     (clock),
        .resetn    (resetn),
        .bus       (bus.slave),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic        port;
        logic [23:0] addr;
        int          delay;
        logic [31:0] data;
        logic [23:0] exp_addr;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.req0_valid = 1'b0;
        bus.req0_addr  = '0;
        bus.req1_valid = 1'b0;
        bus.req1_addr  = '0;
        bus.mem_ready  = 1'b0;
        bus.mem_rdata  = '0;
    endtask

    task automatic apply_reset();
        @(negedge clock);
        resetn = 1'b0;
        clear_inputs();
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
    endtask

    task automatic wait_mem_valid(input string name, output int waited);
        waited = 0;
        do begin
            @(negedge clock);
            waited++;
        end while (!bus.mem_valid && waited < 50);
        check({name, "_mem_valid_seen"}, 64'(bus.mem_valid), 64'd1);
    endtask

    task automatic run_txn(input vec_t v, input string tag);
        int          waited;
        logic [31:0] other_before;
        other_before = v.port ? bus.req0_rdata : bus.req1_rdata;
        if (v.port) begin
            bus.req1_valid = 1'b1;
            bus.req1_addr  = v.addr;
        end else begin
            bus.req0_valid = 1'b1;
            bus.req0_addr  = v.addr;
        end
        wait_mem_valid(tag, waited);
        check({tag, "_latency"}, 64'(waited), 64'd1);
        check({tag, "_mem_addr"}, 64'(bus.mem_addr), 64'(v.exp_addr));
        repeat (v.delay) @(negedge clock);
        check({tag, "_mem_valid_hold"}, 64'(bus.mem_valid), 64'd1);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = v.data;
        @(negedge clock);
        bus.mem_ready  = 1'b0;
        bus.mem_rdata  = '0;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        check({tag, "_ready"}, 64'(v.port ? bus.req1_ready : bus.req0_ready), 64'd1);
        check({tag, "_other_ready"}, 64'(v.port ? bus.req0_ready : bus.req1_ready), 64'd0);
        check({tag, "_rdata"}, 64'(v.port ? bus.req1_rdata : bus.req0_rdata), 64'(v.data));
        check({tag, "_other_rdata"}, 64'(v.port ? bus.req0_rdata : bus.req1_rdata), 64'(other_before));
        check({tag, "_err"}, 64'(v.port ? bus.req1_err : bus.req0_err), 64'd0);
        check({tag, "_gap_mem_valid"}, 64'(bus.mem_valid), 64'd0);
        check({tag, "_done_state"}, 64'(dbg_state), 64'd2);
        @(negedge clock);
        check({tag, "_ready_pulse_end"}, 64'(bus.req0_ready | bus.req1_ready), 64'd0);
        check({tag, "_idle_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          waited;
        int          cnt0;
        int          cnt1;
        int          hi;
        logic        exp_port;
        logic [31:0] d;

        resetn = 1'b1;
        clear_inputs();
        #2 resetn = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_mem_valid", 64'(bus.mem_valid), 64'd0);
        check("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_ready", 64'({bus.req0_ready, bus.req1_ready}), 64'd0);
        check("rst_err", 64'({bus.req0_err, bus.req1_err}), 64'd0);
        check("rst_rdata0", 64'(bus.req0_rdata), 64'd0);
        check("rst_rdata1", 64'(bus.req1_rdata), 64'd0);
        check("rst_state", 64'(dbg_state), 64'd0);
        resetn = 1'b1;
        @(negedge clock);

        vecs[0] = '{1'b0, 24'h100004, 10, 32'hDEADBEEF, 24'h100004};
        vecs[1] = '{1'b1, 24'h12345F,  3, 32'h12345678, 24'h12345C};
        vecs[2] = '{1'b0, 24'h000003,  0, 32'hA5A5A5A5, 24'h000000};
        vecs[3] = '{1'b1, 24'hFFFFFF,  1, 32'h00000001, 24'hFFFFFC};
        vecs[4] = '{1'b0, 24'hABCDE2,  2, 32'hCAFEF00D, 24'hABCDE0};
        for (int i = 0; i < 5; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

        // Both ports held valid from reset: strict alternation starting with port 0.
        apply_reset();
        bus.req0_valid = 1'b1;
        bus.req0_addr  = 24'h000100;
        bus.req1_valid = 1'b1;
        bus.req1_addr  = 24'h000201;
        cnt0 = 0;
        cnt1 = 0;
        for (int i = 0; i < 6; i++) begin
            exp_port = i[0];
            wait_mem_valid($sformatf("rr%0d", i), waited);
            if (i > 0) check($sformatf("rr%0d_gap", i), 64'(waited), 64'd2);
            check($sformatf("rr%0d_mem_addr", i), 64'(bus.mem_addr),
                  exp_port ? 64'h000200 : 64'h000100);
            repeat (2) @(negedge clock);
            d = 32'h5000_0000 + 32'(i);
            exp_q.push_back(d);
            bus.mem_ready = 1'b1;
            bus.mem_rdata = d;
            @(negedge clock);
            bus.mem_ready = 1'b0;
            if (i == 5) begin
                bus.req0_valid = 1'b0;
                bus.req1_valid = 1'b0;
            end
            if (bus.req0_ready) cnt0++;
            if (bus.req1_ready) cnt1++;
            check($sformatf("rr%0d_ready", i),
                  64'(exp_port ? bus.req1_ready : bus.req0_ready), 64'd1);
            check($sformatf("rr%0d_rdata", i),
                  64'(exp_port ? bus.req1_rdata : bus.req0_rdata), 64'(exp_q.pop_front()));
        end
        @(negedge clock);
        check("rr_pulses_port0", 64'(cnt0), 64'd3);
        check("rr_pulses_port1", 64'(cnt1), 64'd3);

        // Requester withdraws while granted: read still completes and responds.
        bus.req1_valid = 1'b1;
        bus.req1_addr  = 24'h000308;
        wait_mem_valid("drop", waited);
        bus.req1_valid = 1'b0;
        repeat (2) @(negedge clock);
        check("drop_mem_valid_kept", 64'(bus.mem_valid), 64'd1);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h7777_0001;
        @(negedge clock);
        bus.mem_ready = 1'b0;
        check("drop_ready", 64'(bus.req1_ready), 64'd1);
        check("drop_rdata", 64'(bus.req1_rdata), 64'h7777_0001);
        @(negedge clock);

        // Stray mem_ready while idle must be ignored.
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'hBAD0_BAD0;
        @(negedge clock);
        bus.mem_ready = 1'b0;
        check("stray_busy", 64'(busy), 64'd0);
        check("stray_ready", 64'({bus.req0_ready, bus.req1_ready}), 64'd0);
        check("stray_rdata1", 64'(bus.req1_rdata), 64'h7777_0001);
        check("stray_rdata0", 64'(bus.req0_rdata), 64'h5000_0004);

        // Asynchronous reset in the middle of ISSUE.
        bus.req0_valid = 1'b1;
        bus.req0_addr  = 24'h000050;
        wait_mem_valid("midrst", waited);
        resetn = 1'b0;
        #1;
        check("midrst_mem_valid", 64'(bus.mem_valid), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_ready", 64'({bus.req0_ready, bus.req1_ready}), 64'd0);
        check("midrst_rdata0", 64'(bus.req0_rdata), 64'd0);
        bus.req0_valid = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
        run_txn('{1'b0, 24'h000045, 1, 32'h600D_0001, 24'h000044}, "post_rst");

`ifdef ARB_TIMEOUT_EN
        bus.req0_valid = 1'b1;
        bus.req0_addr  = 24'h000080;
        wait_mem_valid("tmo", waited);
        hi = 1;
        do begin
            @(negedge clock);
            if (bus.mem_valid) hi++;
        end while (bus.mem_valid && hi < 100);
        bus.req0_valid = 1'b0;
        check("tmo_issue_cycles", 64'(hi), 64'd16);
        check("tmo_ready", 64'(bus.req0_ready), 64'd1);
        check("tmo_err", 64'(bus.req0_err), 64'd1);
        check("tmo_rdata", 64'(bus.req0_rdata), 64'hFFFF_FFFF);
        @(negedge clock);
        check("tmo_err_pulse_end", 64'(bus.req0_err), 64'd0);
`else
        bus.req0_valid = 1'b1;
        bus.req0_addr  = 24'h000080;
        wait_mem_valid("hang", waited);
        bus.req0_valid = 1'b0;
        hi = 1;
        repeat (1000) begin
            @(negedge clock);
            if (bus.mem_valid) hi++;
        end
        check("hang_mem_valid_cycles", 64'(hi), 64'd1001);
        check("hang_err", 64'(bus.req0_err | bus.req1_err), 64'd0);
        apply_reset();
        check("hang_cleared_busy", 64'(busy), 64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
